// File: rtl/sw_src_pkg.sv
// Shared defaults and state encoding for the switch-word source.
package sw_src_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int DEBOUNCE_DEF = 50000;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/btn_debounce.sv
// Generic push-button conditioner: 2-flop sync, stable-period debounce and
// a one-cycle pulse on each debounced 0->1 transition.
module btn_debounce
  import sw_src_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [1:0]       fill;
  logic             raw_s;
  logic             level;
  logic             level_q;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  assign raw_s = sync[1];

  // Two-flop synchronizer; fill marks when sync[1] holds a real sample again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      fill <= '0;
    end else begin
      sync <= {sync[0], raw};
      fill <= {fill[0], 1'b1};
    end
  end

  // Level follows the synced input only after it has differed for a full window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw_s == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= raw_s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A button held through reset would otherwise look like a fresh press, so
  // rises only count once the key has been seen released after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (fill[1] && !raw_s && !level)
        armed <= 1'b1;
    end
  end

  assign press = level & ~level_q & armed;
endmodule

// File: rtl/sw_word_source.sv
// Captures the slide switches on a debounced key press and offers the word
// downstream over valid/ready; flags presses lost while a word is pending.
module sw_word_source
  import sw_src_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun
);
  logic [DATA_W-1:0] sw_m;
  logic [DATA_W-1:0] sw_s;
  logic              press;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] dout_nx;
  logic              valid_nx;
  logic              overrun_nx;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn),
    .press (press)
  );

  // Two-flop synchronizer on every switch bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  // Next-state logic: capture on press, release on transfer, flag lost presses.
  always_comb begin
    state_nx   = state;
    dout_nx    = dout;
    valid_nx   = dout_valid;
    overrun_nx = overrun;
    case (state)
      IDLE: begin
        if (press) begin
          dout_nx  = sw_s;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (dout_ready && press) begin
          dout_nx = sw_s;
        end else if (dout_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else if (press) begin
          overrun_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
      overrun    <= overrun_nx;
    end
  end
endmodule

// File: tb/tb_sw_word_source.sv
// Directed bench for sw_word_source with a word scoreboard checked on transfer.
module tb_sw_word_source;
  localparam int DW = 16;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic [DW-1:0] sw;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  sw_word_source #(
    .DATA_W          (DW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .sw         (sw),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a transfer happens at the next edge whenever valid & ready hold now.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(dout), 32'hDEAD_BEEF);
      else check("word", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; btn = 1'b0; sw = '0; dout_ready = 1'b0;
    tick(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    tick(5);

    // press with A5C3, no consumer: valid after the 7th edge, then held
    sw = 16'hA5C3; btn = 1'b1; exp_q.push_back(16'hA5C3);
    tick(6);
    check("lat_early", 32'(dout_valid), 32'h0);
    tick(1);
    check("lat_valid", 32'(dout_valid), 32'h1);
    check("lat_dout", 32'(dout), 32'hA5C3);
    check("lat_overrun", 32'(overrun), 32'h0);
    tick(13);
    check("held_valid", 32'(dout_valid), 32'h1);
    check("held_dout", 32'(dout), 32'hA5C3);

    // release makes no event
    btn = 1'b0;
    tick(8);
    check("release_valid", 32'(dout_valid), 32'h1);
    check("release_dout", 32'(dout), 32'hA5C3);

    // one-cycle accept, then ready in IDLE does nothing
    dout_ready = 1'b1;
    tick(1);
    check("accept_valid", 32'(dout_valid), 32'h0);
    tick(3);
    check("idle_ready_valid", 32'(dout_valid), 32'h0);
    check("idle_ready_dout", 32'(dout), 32'hA5C3);
    dout_ready = 1'b0;

    // 3-cycle glitch is filtered
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(10);
    check("glitch_valid", 32'(dout_valid), 32'h0);
    check("glitch_cnt", 32'(dut.u_btn.cnt), 32'h0);

    // press 1234, then a second press lands on the accept edge
    sw = 16'h1234; btn = 1'b1; exp_q.push_back(16'h1234);
    tick(7);
    check("p1_valid", 32'(dout_valid), 32'h1);
    check("p1_dout", 32'(dout), 32'h1234);
    btn = 1'b0;
    tick(8);
    sw = 16'h5678; btn = 1'b1; exp_q.push_back(16'h5678);
    tick(6);
    check("same_pre_valid", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    check("same_valid", 32'(dout_valid), 32'h1);
    check("same_dout", 32'(dout), 32'h5678);
    check("same_overrun", 32'(overrun), 32'h0);

    // press while 5678 pending: discarded, overrun set and sticky
    btn = 1'b0;
    tick(8);
    sw = 16'hFFFF; btn = 1'b1;
    tick(6);
    check("ovr_pre", 32'(overrun), 32'h0);
    tick(1);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_dout", 32'(dout), 32'h5678);
    check("ovr_valid", 32'(dout_valid), 32'h1);
    btn = 1'b0;
    tick(8);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    check("ovr_accept_valid", 32'(dout_valid), 32'h0);
    tick(3);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // reset while a word is pending and btn is still held
    sw = 16'hBEEF; btn = 1'b1;
    tick(7);
    check("pre_rst_valid", 32'(dout_valid), 32'h1);
    check("pre_rst_dout", 32'(dout), 32'hBEEF);
    rst = 1'b1;
    tick(1);
    check("rst2_dout", 32'(dout), 32'h0);
    check("rst2_valid", 32'(dout_valid), 32'h0);
    check("rst2_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check("held_through_rst", 32'(dout_valid), 32'h0);
    end
    btn = 1'b0;
    tick(8);
    sw = 16'h0F0F; btn = 1'b1; exp_q.push_back(16'h0F0F);
    tick(7);
    check("repress_valid", 32'(dout_valid), 32'h1);
    check("repress_dout", 32'(dout), 32'h0F0F);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    btn = 1'b0;
    check("repress_accept", 32'(dout_valid), 32'h0);
    tick(2);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
